// File: rtl/step_counter_ctl_if.sv
// Control/status bundle for step_counter_ctl: load/step controls in, count and sequencing flags out.
interface step_counter_ctl_if #(
  parameter int unsigned WIDTH = 12
) ();
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic             cnt_enb;
  logic [1:0]       xmode;
  logic             dir;
  logic             periodic;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             done;
  logic             busy;

  modport master (
    output load, load_val, limit, cnt_enb, xmode, dir, periodic,
    input  count, tc, done, busy
  );

  modport slave (
    input  load, load_val, limit, cnt_enb, xmode, dir, periodic,
    output count, tc, done, busy
  );
endinterface

// File: rtl/step_counter_ctl.sv
// Loadable up/down step counter with limit compare; stops in DONE (one-shot) or reloads (periodic).
module step_counter_ctl #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned STEP1 = 1,
  parameter int unsigned STEP2 = 4,
  parameter int unsigned STEP3 = 8
) (
  input logic               clk,
  input logic               rst_n,
  step_counter_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Steps widened by one bit so every compare is carry-exact.
  localparam logic [WIDTH:0] Step1W = (WIDTH + 1)'(STEP1);
  localparam logic [WIDTH:0] Step2W = (WIDTH + 1)'(STEP2);
  localparam logic [WIDTH:0] Step3W = (WIDTH + 1)'(STEP3);

  logic [1:0] rst_sync_q;
  logic       rst_core_n;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   step;
  logic [WIDTH:0]   count_w;
  logic [WIDTH:0]   limit_w;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH:0]   lim_plus_w;
  logic             hit;
  logic [WIDTH-1:0] nxt;

  // Asynchronous assertion, release aligned to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_core_n = rst_sync_q[1];

  always_comb begin
    step = '0;
    unique case (bus.xmode)
      2'b00: step = '0;
      2'b01: step = Step1W;
      2'b10: step = Step2W;
      2'b11: step = Step3W;
      default: step = '0;
    endcase
  end

  assign count_w    = {1'b0, count_q};
  assign limit_w    = {1'b0, bus.limit};
  assign sum_w      = count_w + step;
  assign diff_w     = count_w - step;
  assign lim_plus_w = limit_w + step;

  always_comb begin
    hit = 1'b0;
    nxt = count_q;
    if (step == '0) begin
      hit = (count_q == bus.limit);
    end else if (!bus.dir) begin
      hit = (sum_w >= limit_w);
      nxt = sum_w[WIDTH-1:0];
    end else begin
      // diff_w cannot underflow on the no-hit path since count > limit + step.
      hit = (count_w <= lim_plus_w);
      nxt = diff_w[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      state_d = StRun;
      count_d = bus.load_val;
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StRun: begin
          if (bus.cnt_enb) begin
            if (hit) begin
              tc_d = 1'b1;
              if (bus.periodic) begin
                count_d = bus.load_val;
              end else begin
                count_d = bus.limit;
                state_d = StDone;
              end
            end else begin
              count_d = nxt;
            end
          end
        end
        StDone: state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
    done_d = (state_d == StDone);
    busy_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q <= StIdle;
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_step_counter_ctl.sv
// Directed bench for step_counter_ctl with hand-computed expectations (WIDTH=12, steps 1/4/8).
module tb_step_counter_ctl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  step_counter_ctl_if #(.WIDTH(12)) bus ();

  step_counter_ctl #(
    .WIDTH(12),
    .STEP1(1),
    .STEP2(4),
    .STEP3(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int cnt, input bit tc, input bit done,
                            input bit busy);
    check({tag, ".count"}, 32'(bus.count), 32'(cnt));
    check({tag, ".tc"}, 32'(bus.tc), 32'(tc));
    check({tag, ".done"}, 32'(bus.done), 32'(done));
    check({tag, ".busy"}, 32'(bus.busy), 32'(busy));
  endtask

  task automatic setup(input int lv, input int lim, input bit d, input logic [1:0] xm,
                       input bit per);
    bus.load_val = 12'(lv);
    bus.limit    = 12'(lim);
    bus.dir      = d;
    bus.xmode    = xm;
    bus.periodic = per;
  endtask

  task automatic do_load();
    bus.load    = 1'b1;
    bus.cnt_enb = 1'b0;
    tick();
    bus.load    = 1'b0;
  endtask

  int exp_up[5]   = '{4, 8, 12, 16, 20};
  int exp_dn[4]   = '{2, 10, 2, 10};
  bit exp_dntc[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.cnt_enb  = 1'b1;
    setup(0, 0, 1'b0, 2'b00, 1'b0);
    repeat (2) tick();
    expect_out("reset", 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (3) tick();
    // IDLE ignores cnt_enb.
    bus.xmode = 2'b01;
    tick();
    expect_out("idle_hold", 0, 1'b0, 1'b0, 1'b0);

    // Up by 4 to 20, one-shot.
    setup(0, 20, 1'b0, 2'b10, 1'b0);
    do_load();
    expect_out("up_load", 0, 1'b0, 1'b0, 1'b1);
    bus.cnt_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("up_cnt%0d", i), 32'(bus.count), 32'(exp_up[i]));
      check($sformatf("up_tc%0d", i), 32'(bus.tc), 32'(i == 4));
    end
    expect_out("up_done", 20, 1'b1, 1'b1, 1'b0);
    tick();
    expect_out("done_hold", 20, 1'b0, 1'b1, 1'b0);

    // Load in DONE with cnt_enb high: load wins.
    bus.load_val = 12'd7;
    bus.load     = 1'b1;
    bus.cnt_enb  = 1'b1;
    tick();
    bus.load = 1'b0;
    expect_out("done_load", 7, 1'b0, 1'b0, 1'b1);

    // Down by 8 from 10 to 0, periodic.
    setup(10, 0, 1'b1, 2'b11, 1'b1);
    do_load();
    expect_out("dn_load", 10, 1'b0, 1'b0, 1'b1);
    bus.cnt_enb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("dn_cnt%0d", i), 32'(bus.count), 32'(exp_dn[i]));
      check($sformatf("dn_tc%0d", i), 32'(bus.tc), 32'(exp_dntc[i]));
    end
    bus.cnt_enb = 1'b0;
    tick();
    expect_out("run_hold", 10, 1'b0, 1'b0, 1'b1);

    // Async reset mid-RUN clears outputs before the next edge.
    bus.cnt_enb = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_rst", 0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    expect_out("post_rst", 0, 1'b0, 1'b0, 1'b0);

    // Top of range: 4090 + 8 clamps to 4095, no wrap.
    setup(4090, 4095, 1'b0, 2'b11, 1'b0);
    do_load();
    bus.cnt_enb = 1'b1;
    tick();
    expect_out("clamp", 4095, 1'b1, 1'b1, 1'b0);

    // Down with load_val below limit hits at once.
    setup(3, 10, 1'b1, 2'b01, 1'b0);
    do_load();
    bus.cnt_enb = 1'b1;
    tick();
    expect_out("wrong_side", 10, 1'b1, 1'b1, 1'b0);

    // Step 0 with count==limit==load_val, periodic: tc every enabled cycle.
    setup(7, 7, 1'b0, 2'b00, 1'b1);
    do_load();
    expect_out("s0_load", 7, 1'b0, 1'b0, 1'b1);
    bus.cnt_enb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("s0_en%0d", i), 7, 1'b1, 1'b0, 1'b1);
    end
    bus.cnt_enb = 1'b0;
    tick();
    expect_out("s0_dis", 7, 1'b0, 1'b0, 1'b1);

    // Mid-RUN reload with cnt_enb high.
    setup(100, 200, 1'b0, 2'b01, 1'b0);
    bus.load    = 1'b1;
    bus.cnt_enb = 1'b1;
    tick();
    bus.load = 1'b0;
    expect_out("mid_load", 100, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("mid_step", 101, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
